seq_bit_serializer: RTL and testbench
=====================================

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of each parallel input word.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of buffered words; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 shifts bit DATA_W-1 first, 0 shifts bit 0 first.
REQ-004 The block SHALL have parameter IDLE_BIT, default 0, giving the value driven on x when no bit is valid.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: parallel word to serialize.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept a word this cycle.
REQ-010 The block SHALL have port x, output, 1 bit: registered serial bit stream for the downstream 1010 sequence detector.
REQ-011 The block SHALL have port x_valid, output, 1 bit: x carries a data bit this cycle.
REQ-012 The block SHALL have port word_start, output, 1 bit: high on the cycle x carries the first bit of a word.
REQ-013 The block SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1 bits: words currently held in the FIFO, excluding the word in the shifter.

Function
REQ-014 A push SHALL occur on a rising edge where in_valid and in_ready are both 1; the word SHALL be written at the FIFO tail.
REQ-015 in_ready SHALL equal (fifo_count < FIFO_DEPTH) and SHALL be 0 while rst is 1; there is no full-with-pop bypass, so in_ready is 0 when full even on a cycle that pops.
REQ-016 in_valid while in_ready is 0 SHALL cause no state change; in_data SHALL be ignored whenever in_valid is 0.
REQ-017 The block SHALL have a two-state FSM: IDLE and SHIFT.
REQ-018 In IDLE with fifo_count > 0, the next edge SHALL pop the FIFO head into the shifter, load bit counter DATA_W-1, and enter SHIFT.
REQ-019 Each edge in SHIFT SHALL advance one bit and decrement the bit counter.
REQ-020 At the edge that ends the last bit (counter 0): if fifo_count > 0, the next word SHALL load with no gap cycle; otherwise the FSM SHALL return to IDLE.
REQ-021 Latency: a word pushed at edge N into an empty FIFO with FSM in IDLE SHALL present its first bit on x, with x_valid=1 and word_start=1, in the cycle following edge N+1.
REQ-022 Each word SHALL produce exactly DATA_W consecutive x_valid cycles; bit order follows MSB_FIRST.
REQ-023 In IDLE, x SHALL equal IDLE_BIT, and x_valid and word_start SHALL be 0.
REQ-024 On a simultaneous push and pop, fifo_count SHALL be unchanged and both operations SHALL take effect.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Words SHALL be emitted in push order with no loss or duplication.

Reset
REQ-027 When rst is 1 at an edge, the block SHALL set: FSM IDLE, pointers 0, fifo_count 0, bit counter 0, x=IDLE_BIT, x_valid 0, word_start 0.
REQ-028 Reset asserted mid-word or with a non-empty FIFO SHALL discard all buffered and partial data, with no further bits emitted.
REQ-029 A push coincident with rst SHALL be ignored.
REQ-030 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-031 The bench SHALL cover: single push of 0xA5 (MSB_FIRST=1) at edge N -> x = 1,0,1,0,0,1,0,1 with x_valid high for 8 cycles starting after edge N+1, word_start high on the first of them only, then x=0 and x_valid=0.
REQ-032 The bench SHALL cover: back-to-back pushes 0xAA, 0xAA -> 16 contiguous valid bits 1010101010101010 with no gap, and word_start high on bits 0 and 8; a non-overlapping 1010 detector on x SHALL report 4 detections.
REQ-033 The bench SHALL cover: 6 consecutive push attempts with in_valid held high while draining -> the first word loads the shifter, fifo_count reaches 4, in_ready is 0 until the first pop, and all words are later emitted in order.
REQ-034 The bench SHALL cover: rst pulsed for 1 cycle during bit 3 of a word with 2 words queued -> the next cycle shows x_valid=0, fifo_count=0 and in_ready=1, and no remaining bits appear.
REQ-035 The bench SHALL cover: MSB_FIRST=0 with a push of 0x05 -> x = 1,0,1,0,0,0,0,0.
REQ-036 The bench SHALL cover: full FIFO with in_valid=1 during a pop cycle -> no push that cycle, fifo_count goes from 4 to 3, and the offered word is accepted on the next edge.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
// Buffers parallel words in a small FIFO and shifts them out one bit per clock
// on a registered serial line (x) that feeds a downstream 1010 sequence detector.
// A new word follows the previous one with no gap cycle whenever the FIFO holds
// one. FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
//
// FSM states
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | shifter empty, x = IDLE_BIT, waiting for a word in the FIFO
//   ST_SHIFT | a word is on x; bit_cnt counts the bits still to follow it

module seq_bit_serializer #(
  parameter int   DATA_W     = 8,
  parameter int   FIFO_DEPTH = 4,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          x,
  output logic                          x_valid,
  output logic                          word_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               word_start_q, word_start_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic               load;
  logic               advance;
  logic               fifo_empty;
  logic               last_bit;
  logic [DATA_W-1:0]  head_word;

  // No full-with-pop bypass: a full FIFO refuses a word even on a popping cycle.
  assign in_ready   = ~rst & (count_q < CW'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign fifo_empty = (count_q == '0);
  assign last_bit   = (bit_cnt_q == '0);
  assign head_word  = mem_q[rd_ptr_q];

  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign word_start = word_start_q;
  assign fifo_count = count_q;

  // Next state: load a word from IDLE, or chain the next one off the last bit.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          advance = 1'b1;
        end else if (!fifo_empty) begin
          pop  = 1'b1;
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO pointer and occupancy update; pointers wrap modulo FIFO_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Shifter: x is registered, shift_q holds the bits still to come after x.
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    x_d          = IDLE_BIT;
    x_valid_d    = 1'b0;
    word_start_d = 1'b0;
    if (load) begin
      bit_cnt_d    = BW'(DATA_W - 1);
      x_valid_d    = 1'b1;
      word_start_d = 1'b1;
      if (MSB_FIRST != 0) begin
        x_d     = head_word[DATA_W-1];
        shift_d = head_word << 1;
      end else begin
        x_d     = head_word[0];
        shift_d = head_word >> 1;
      end
    end else if (advance) begin
      bit_cnt_d = bit_cnt_q - BW'(1);
      x_valid_d = 1'b1;
      if (MSB_FIRST != 0) begin
        x_d     = shift_q[DATA_W-1];
        shift_d = shift_q << 1;
      end else begin
        x_d     = shift_q[0];
        shift_d = shift_q >> 1;
      end
    end
  end

  // Shifter and serial output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      x_q          <= IDLE_BIT;
      x_valid_q    <= 1'b0;
      word_start_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      x_q          <= x_d;
      x_valid_q    <= x_valid_d;
      word_start_q <= word_start_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Testbench for seq_bit_serializer: directed scenarios followed by a random
// phase, all checked every cycle against a queue-based behavioural model.

module tb_seq_bit_serializer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       x;
  logic       x_valid;
  logic       word_start;
  logic [2:0] fifo_count;

  logic       l_in_valid;
  logic [7:0] l_in_data;
  logic       l_in_ready;
  logic       l_x;
  logic       l_x_valid;
  logic       l_word_start;
  logic [2:0] l_fifo_count;

  seq_bit_serializer #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .x_valid(x_valid), .word_start(word_start), .fifo_count(fifo_count)
  );

  seq_bit_serializer #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .x(l_x), .x_valid(l_x_valid), .word_start(l_word_start), .fifo_count(l_fifo_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: words waiting, bits still to follow the current one
  logic [7:0] m_fifo[$];
  logic       m_rest[$];
  logic       m_xv;
  logic       m_x;
  logic       m_ws;

  // observed stream of the MSB-first instance
  logic       obs[$];
  int         ws_idx[$];
  logic [3:0] det_sh;
  int         det_fill;
  int         det_cnt;

  logic [7:0] w [6];
  logic [7:0] lv;

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_tests++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic model_edge();
    bit         can_push;
    logic [7:0] wd;
    if (rst) begin
      m_fifo.delete();
      m_rest.delete();
      m_xv = 1'b0;
      m_x  = 1'b0;
      m_ws = 1'b0;
      return;
    end
    can_push = in_valid && (m_fifo.size() < DEPTH);
    if (m_xv && m_rest.size() > 0) begin
      m_x  = m_rest.pop_front();
      m_ws = 1'b0;
    end else if (m_fifo.size() > 0) begin
      wd = m_fifo.pop_front();
      m_rest.delete();
      for (int i = 7; i >= 0; i--) m_rest.push_back(wd[i]);
      m_x  = m_rest.pop_front();
      m_xv = 1'b1;
      m_ws = 1'b1;
    end else begin
      m_xv = 1'b0;
      m_x  = 1'b0;
      m_ws = 1'b0;
    end
    if (can_push) m_fifo.push_back(in_data);
  endtask

  task automatic clear_obs();
    obs.delete();
    ws_idx.delete();
    det_sh   = 4'b0;
    det_fill = 0;
    det_cnt  = 0;
  endtask

  function automatic logic [31:0] pack_obs(input int start, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (start + i < obs.size()) v = {v[30:0], obs[start+i]};
      else v = {v[30:0], 1'bx};
    end
    return v;
  endfunction

  // one clock: model follows the edge, then DUT outputs are compared 1 ns later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("x_valid", x_valid, m_xv);
    chk("word_start", word_start, m_ws);
    chk("x", x, m_x);
    chk("fifo_count", fifo_count, m_fifo.size());
    chk("in_ready", in_ready, (!rst && m_fifo.size() < DEPTH));
    if (x_valid === 1'b1) begin
      obs.push_back(x);
      if (word_start === 1'b1) ws_idx.push_back(obs.size() - 1);
      det_sh = {det_sh[2:0], x};
      det_fill++;
      if (det_fill >= 4 && det_sh == 4'b1010) begin
        det_cnt++;
        det_fill = 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    l_in_valid = 1'b0; l_in_data = '0;
    m_xv = 1'b0; m_x = 1'b0; m_ws = 1'b0;
    clear_obs();

    // reset state
    in_valid = 1'b1; in_data = 8'h3C;
    tick(); tick();
    in_valid = 1'b0;
    chk("rst_x_valid", x_valid, 1'b0);
    chk("rst_x", x, 1'b0);
    chk("rst_ws", word_start, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ready_low", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1'b1);

    // single word 0xA5
    clear_obs();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("a5_not_yet", x_valid, 1'b0);
    tick();
    chk("a5_first_valid", x_valid, 1'b1);
    chk("a5_first_ws", word_start, 1'b1);
    repeat (7) tick();
    tick();
    chk("a5_end_valid", x_valid, 1'b0);
    chk("a5_end_x", x, 1'b0);
    chk("a5_nbits", obs.size(), 8);
    chk("a5_bits", pack_obs(0, 8), 32'hA5);
    chk("a5_ws_count", ws_idx.size(), 1);

    // back-to-back 0xAA, 0xAA
    clear_obs();
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (18) tick();
    chk("aa_nbits", obs.size(), 16);
    chk("aa_bits", pack_obs(0, 16), 32'hAAAA);
    chk("aa_ws_count", ws_idx.size(), 2);
    chk("aa_ws0", (ws_idx.size() > 0) ? ws_idx[0] : -1, 0);
    chk("aa_ws1", (ws_idx.size() > 1) ? ws_idx[1] : -1, 8);
    chk("aa_detect", det_cnt, 4);

    // six push attempts with in_valid held high; fill, full stall, in-order drain
    clear_obs();
    for (int k = 0; k < 6; k++) w[k] = 8'($urandom);
    in_valid = 1'b1;
    in_data = w[0]; tick();
    chk("fill_cnt1", fifo_count, 3'd1);
    in_data = w[1]; tick();
    chk("fill_cnt_pushpop", fifo_count, 3'd1);
    chk("fill_first_ws", word_start, 1'b1);
    in_data = w[2]; tick();
    in_data = w[3]; tick();
    in_data = w[4]; tick();
    chk("fill_cnt4", fifo_count, 3'd4);
    chk("fill_ready0", in_ready, 1'b0);
    in_data = w[5];
    repeat (4) begin
      tick();
      chk("full_cnt", fifo_count, 3'd4);
      chk("full_ready", in_ready, 1'b0);
    end
    tick();
    chk("full_pop_cnt3", fifo_count, 3'd3);
    chk("full_pop_ws", word_start, 1'b1);
    tick();
    chk("full_accept_next", fifo_count, 3'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (x_valid === 1'b0 && fifo_count === 3'd0) break;
      tick();
    end
    chk("drain_idle", {x_valid, fifo_count}, 4'd0);
    chk("drain_nbits", obs.size(), 48);
    for (int k = 0; k < 6; k++) chk($sformatf("order_w%0d", k), pack_obs(8 * k, 8), {24'd0, w[k]});

    // reset during bit 3 with two words queued
    clear_obs();
    in_valid = 1'b1;
    in_data = 8'($urandom); tick();
    in_data = 8'($urandom); tick();
    in_data = 8'($urandom); tick();
    in_valid = 1'b0;
    chk("rstmid_cnt2", fifo_count, 3'd2);
    tick(); tick();
    chk("rstmid_bit3_valid", x_valid, 1'b1);
    chk("rstmid_bits_before", obs.size(), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_xv", x_valid, 1'b0);
    chk("rstmid_cnt", fifo_count, 3'd0);
    chk("rstmid_ready", in_ready, 1'b1);
    repeat (20) tick();
    chk("rstmid_no_bits", obs.size(), 4);

    // LSB-first instance with 0x05
    l_in_valid = 1'b1; l_in_data = 8'h05;
    tick();
    l_in_valid = 1'b0;
    tick();
    chk("lsb_first_valid", l_x_valid, 1'b1);
    chk("lsb_first_ws", l_word_start, 1'b1);
    lv = {7'd0, l_x};
    repeat (7) begin
      tick();
      chk("lsb_valid", l_x_valid, 1'b1);
      lv = {lv[6:0], l_x};
    end
    chk("lsb_bits", lv, 8'b1010_0000);
    tick();
    chk("lsb_end_valid", l_x_valid, 1'b0);

    // random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) < 2);
      in_valid = ($urandom_range(0, 99) < 55);
      in_data  = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (x_valid === 1'b0 && fifo_count === 3'd0) break;
      tick();
    end
    chk("rand_drain_idle", {x_valid, fifo_count}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
